rv_port_arbiter: RTL

Round-robin arbiter that shares one ready/valid register resource among the four user ports (A–D) of the AXI-lite to ready/valid bridge. Write and read channels are arbitrated independently, each by its own two-state FSM with a per-transaction timeout. Requests are forwarded to a single resource interface, tagged with the granting port index. Completions, including error status and read data, are returned only to the granted port.

---
 rtl/rv_port_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rv_port_arbiter.sv
// Round-robin arbiter sharing one ready/valid register resource among four ports.
// Write and read channels each run an independent IDLE/BUSY arbiter with a per-transaction timeout.

module rv_arb_channel #(
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       busy,
  output logic [1:0] grant,
  output logic       timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [15:0] LAST  = TO_EN ? 16'(TIMEOUT - 1) : 16'd0;

  state_t      state;
  logic [1:0]  ptr;
  logic [15:0] cnt;
  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;

  // First active request at or after the round-robin pointer, wrapping mod 4.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign busy    = (state == BUSY);
  assign timeout = TO_EN && busy && !done && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      grant <= 2'd0;
      cnt   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant <= pick;
            cnt   <= 16'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (done || timeout) begin
            ptr   <= grant + 2'd1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module rv_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                    S00_AXI_aclk,
  input  logic                    S00_AXI_aresetn,
  input  logic [3:0]              req_wvalid_i,
  input  logic [4*DATA_WIDTH-1:0] req_wdata_i,
  output logic [3:0]              req_wready_o,
  output logic [3:0]              req_werror_o,
  input  logic [3:0]              req_rready_i,
  output logic [3:0]              req_rvalid_o,
  output logic [DATA_WIDTH-1:0]   req_rdata_o,
  output logic [3:0]              req_rerror_o,
  output logic                    res_wvalid_o,
  output logic [1:0]              res_wsel_o,
  output logic [DATA_WIDTH-1:0]   res_wdata_o,
  input  logic                    res_wready_i,
  input  logic                    res_werror_i,
  output logic                    res_rready_o,
  output logic [1:0]              res_rsel_o,
  input  logic                    res_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   res_rdata_i,
  input  logic                    res_rerror_i,
  output logic                    wtimeout_o,
  output logic                    rtimeout_o
);

  logic                  w_busy, r_busy, w_to, r_to;
  logic [1:0]            w_grant, r_grant;
  logic [DATA_WIDTH-1:0] wdata_arr [4];

  rv_arb_channel #(.TIMEOUT(TIMEOUT)) u_wch (
    .clk(S00_AXI_aclk), .rst_n(S00_AXI_aresetn), .req(req_wvalid_i), .done(res_wready_i),
    .busy(w_busy), .grant(w_grant), .timeout(w_to)
  );

  rv_arb_channel #(.TIMEOUT(TIMEOUT)) u_rch (
    .clk(S00_AXI_aclk), .rst_n(S00_AXI_aresetn), .req(req_rready_i), .done(res_rvalid_i),
    .busy(r_busy), .grant(r_grant), .timeout(r_to)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wdata_arr[i] = req_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Outputs are gated by reset so a transaction in flight when reset hits is silently dropped.
  always_comb begin
    res_wvalid_o = 1'b0;
    res_wsel_o   = 2'd0;
    res_wdata_o  = '0;
    req_wready_o = 4'd0;
    req_werror_o = 4'd0;
    wtimeout_o   = 1'b0;
    if (S00_AXI_aresetn && w_busy) begin
      res_wvalid_o = 1'b1;
      res_wsel_o   = w_grant;
      res_wdata_o  = wdata_arr[w_grant];
      if (res_wready_i) begin
        req_wready_o[w_grant] = 1'b1;
        req_werror_o[w_grant] = res_werror_i;
      end else if (w_to) begin
        req_wready_o[w_grant] = 1'b1;
        req_werror_o[w_grant] = 1'b1;
        wtimeout_o            = 1'b1;
      end
    end
  end

  always_comb begin
    res_rready_o = 1'b0;
    res_rsel_o   = 2'd0;
    req_rvalid_o = 4'd0;
    req_rerror_o = 4'd0;
    req_rdata_o  = '0;
    rtimeout_o   = 1'b0;
    if (S00_AXI_aresetn && r_busy) begin
      res_rready_o = 1'b1;
      res_rsel_o   = r_grant;
      if (res_rvalid_i) begin
        req_rvalid_o[r_grant] = 1'b1;
        req_rerror_o[r_grant] = res_rerror_i;
        req_rdata_o           = res_rdata_i;
      end else if (r_to) begin
        req_rvalid_o[r_grant] = 1'b1;
        req_rerror_o[r_grant] = 1'b1;
        rtimeout_o            = 1'b1;
      end
    end
  end

endmodule
